lpc_synth: RTL and testbench

All-pole LPC synthesis filter that reconstructs audio samples from a prediction residual using the direct-form coefficients produced by the Levinson-Durbin recursion. It is the decoder-side counterpart of the coefficient datapath. Coefficients are loaded into a shadow bank and committed atomically. Residual samples are filtered one at a time with a single time-multiplexed multiply-accumulate (MAC) over `ORDER` taps.

---
 rtl/lpc_pkg.sv | 15 +
 rtl/lpc_synth_mac.sv | 70 +++++++
 rtl/lpc_synth.sv | 138 +++++++++++++
 tb/tb_lpc_synth.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC synthesis filter.
package lpc_pkg;

    localparam int COEF_FRAC  = 28;
    localparam int COEF_W_DEF = 32;
    localparam int DATA_W_DEF = 16;

    typedef logic signed [COEF_W_DEF-1:0] coef_t;
    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam longint ROUND_K = 64'sd1 <<< (COEF_FRAC - 1);

endpackage

// File: rtl/lpc_synth_mac.sv
// Time-multiplexed MAC with round-half-up output stage.
// LPC_SYNTH_SAT_EN selects clamping instead of two's-complement wrap.
module lpc_synth_mac
    import lpc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 56
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic signed [DATA_W-1:0] e_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] samp_i,
    output logic signed [DATA_W-1:0] res_o
);

    localparam int PW = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] SMAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    logic signed [PW-1:0]    prod_w;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_q, prod_d;
    logic signed [ACC_W-1:0] sum_w, rnd_w, shr_w;

    assign prod_w = PW'(coef_i) * PW'(samp_i);
    assign sum_w  = acc_q - prod_q;
    assign rnd_w  = sum_w + ACC_W'(ROUND_K);
    assign shr_w  = rnd_w >>> COEF_FRAC;

    // Product is registered, so the last tap is folded in by sum_w.
    always_comb begin
        acc_d  = acc_q;
        prod_d = prod_q;
        if (load_i) begin
            acc_d  = ACC_W'(e_i) <<< COEF_FRAC;
            prod_d = '0;
        end else if (step_i) begin
            acc_d  = sum_w;
            prod_d = ACC_W'(prod_w);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            prod_q <= '0;
        end else begin
            acc_q  <= acc_d;
            prod_q <= prod_d;
        end
    end

`ifdef LPC_SYNTH_SAT_EN
    always_comb begin
        res_o = DATA_W'(shr_w);
        if (shr_w > SMAX) begin
            res_o = SMAX[DATA_W-1:0];
        end else if (shr_w < SMIN) begin
            res_o = SMIN[DATA_W-1:0];
        end
    end
`else
    assign res_o = DATA_W'(shr_w);
`endif

endmodule

// File: rtl/lpc_synth.sv
// All-pole LPC synthesis filter: shadow/active coefficient banks, history ring, FSM.
// Output clamping is enabled by defining LPC_SYNTH_SAT_EN.
module lpc_synth
    import lpc_pkg::*;
#(
    parameter int ORDER  = 10,
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 56
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [$clog2(ORDER)-1:0] coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_commit,
    input  logic                     hist_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PW = $clog2(ORDER);
    localparam int TW = $clog2(ORDER + 2);

    state_t                  state_q;
    logic [TW-1:0]           tap_q;
    logic [PW-1:0]           wptr_q, rd_idx, ci_idx;
    logic signed [COEF_W-1:0] shadow_q [ORDER];
    logic signed [COEF_W-1:0] active_q [ORDER];
    logic signed [DATA_W-1:0] hist_q [ORDER];
    logic                    commit_q, clr_q, valid_q;
    logic signed [DATA_W-1:0] data_q, mac_res;
    logic                    pend, accept, last_tap;
    int                      tap_i, rd_i;

    assign pend      = commit_q | clr_q;
    assign in_ready  = (state_q == IDLE) && !pend;
    assign accept    = in_ready && in_valid;
    assign last_tap  = (tap_q == TW'(ORDER + 1));
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // s[n-k] sits k slots behind the write pointer.
    always_comb begin
        tap_i = int'(tap_q);
        if (tap_q == '0 || last_tap) begin
            tap_i = 1;
        end
        rd_i = int'(wptr_q) + ORDER - tap_i;
        if (rd_i >= ORDER) begin
            rd_i = rd_i - ORDER;
        end
        rd_idx = PW'(rd_i);
        ci_idx = PW'(tap_i - 1);
    end

    lpc_synth_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .step_i (state_q == MAC),
        .e_i    (in_data),
        .coef_i (active_q[ci_idx]),
        .samp_i (hist_q[rd_idx]),
        .res_o  (mac_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            wptr_q   <= '0;
            commit_q <= 1'b0;
            clr_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < ORDER; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                hist_q[i]   <= '0;
            end
        end else begin
            if (coef_we && int'(coef_idx) < ORDER) begin
                shadow_q[coef_idx] <= coef_data;
            end
            commit_q <= commit_q | coef_commit;
            clr_q    <= clr_q | hist_clr;
            unique case (state_q)
                IDLE: begin
                    if (pend) begin
                        if (commit_q) begin
                            for (int i = 0; i < ORDER; i++) begin
                                active_q[i] <= shadow_q[i];
                            end
                            commit_q <= coef_commit;
                        end
                        if (clr_q) begin
                            for (int i = 0; i < ORDER; i++) begin
                                hist_q[i] <= '0;
                            end
                            clr_q <= hist_clr;
                        end
                    end else if (in_valid) begin
                        tap_q   <= TW'(1);
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        data_q  <= mac_res;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        hist_q[wptr_q] <= data_q;
                        wptr_q  <= (wptr_q == PW'(ORDER - 1)) ? '0 : wptr_q + 1'b1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_synth.sv
// Directed and randomized bench for lpc_synth against a direct-form reference model.
module tb_lpc_synth;

    localparam int ORDER = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               coef_we, coef_commit, hist_clr;
    logic [3:0]         coef_idx;
    logic signed [31:0] coef_data;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0] in_data, out_data;

    int total = 0;
    int fails = 0;
    longint coef_m [ORDER];
    longint shadow_m [ORDER];
    longint hist_m [ORDER];

    lpc_synth #(
        .ORDER (ORDER),
        .DATA_W(16),
        .COEF_W(32),
        .ACC_W (56)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .coef_commit(coef_commit),
        .hist_clr   (hist_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("ready_valid_excl", in_ready && out_valid, 0);
    endtask

    // s[n] = e[n] - sum a_i * s[n-i], computed directly from the recurrence.
    function automatic logic signed [15:0] mdl(input logic signed [15:0] e);
        longint acc, r;
        logic signed [15:0] s;
        acc = longint'(e) * 268435456;
        for (int i = 0; i < ORDER; i++) acc -= coef_m[i] * hist_m[i];
        r = (acc + 134217728) >>> 28;
`ifdef LPC_SYNTH_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        s = r[15:0];
        for (int i = ORDER - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = longint'(s);
        return s;
    endfunction

    task automatic commit_model();
        for (int i = 0; i < ORDER; i++) coef_m[i] = shadow_m[i];
    endtask

    task automatic clear_model();
        for (int i = 0; i < ORDER; i++) hist_m[i] = 0;
    endtask

    task automatic wr_coef(input int idx, input logic signed [31:0] v);
        coef_we = 1'b1;
        coef_idx = 4'(idx);
        coef_data = v;
        tick();
        coef_we = 1'b0;
        shadow_m[idx] = longint'(v);
    endtask

    task automatic pulse(input logic cm, input logic cl);
        coef_commit = cm;
        hist_clr = cl;
        tick();
        coef_commit = 1'b0;
        hist_clr = 1'b0;
    endtask

    task automatic accept(input logic signed [15:0] e);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data = e;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish(output logic signed [15:0] s, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("out_valid_wait", out_valid, 1);
        s = out_data;
        tick();
    endtask

    task automatic send(input logic signed [15:0] e, output logic signed [15:0] s,
                        output int lat);
        accept(e);
        finish(s, lat);
    endtask

    initial begin
        logic signed [15:0] s, sd, e;
        logic signed [15:0] m;
        int lat;
        int imp_exp [7];
        logic cl;
        imp_exp = '{1000, 500, 250, 125, 63, 32, 16};

        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        coef_we = 1'b0;
        coef_idx = '0;
        coef_data = '0;
        coef_commit = 1'b0;
        hist_clr = 1'b0;
        for (int i = 0; i < ORDER; i++) begin
            coef_m[i] = 0;
            shadow_m[i] = 0;
            hist_m[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        send(16'sd1000, s, lat);
        m = mdl(16'sd1000);
        chk("zero_coef_out", s, 1000);
        chk("zero_coef_latency", lat, ORDER + 1);

        wr_coef(0, 32'shF8000000);
        pulse(1'b1, 1'b1);
        commit_model();
        clear_model();
        for (int k = 0; k < 7; k++) begin
            e = (k == 0) ? 16'sd1000 : 16'sd0;
            send(e, s, lat);
            m = mdl(e);
            chk("impulse_half", s, imp_exp[k]);
        end

        wr_coef(0, 32'shF0000000);
        pulse(1'b1, 1'b1);
        commit_model();
        clear_model();
        send(16'sd30000, s, lat);
        m = mdl(16'sd30000);
        chk("ovf_first", s, 30000);
        send(16'sd30000, s, lat);
        m = mdl(16'sd30000);
`ifdef LPC_SYNTH_SAT_EN
        chk("ovf_second_sat", s, 32767);
`else
        chk("ovf_second_wrap", s, -5536);
`endif

        out_ready = 1'b0;
        accept(16'sd100);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("stall_latency", lat, ORDER + 1);
        sd = out_data;
        chk("stall_value", sd, mdl(16'sd100));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", out_data, sd);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        for (int i = 0; i < ORDER; i++) wr_coef(i, 32'($urandom));
        e = 16'($urandom);
        accept(e);
        tick();
        tick();
        pulse(1'b1, 1'b0);
        finish(s, lat);
        chk("commit_old_bank", s, mdl(e));
        chk("commit_pend_ready", in_ready, 0);
        tick();
        chk("commit_done_ready", in_ready, 1);
        commit_model();
        e = 16'($urandom);
        send(e, s, lat);
        chk("commit_new_bank", s, mdl(e));

        e = 16'($urandom);
        accept(e);
        tick();
        pulse(1'b0, 1'b1);
        finish(s, lat);
        chk("clr_old_hist", s, mdl(e));
        chk("clr_pend_ready", in_ready, 0);
        tick();
        chk("clr_done_ready", in_ready, 1);
        clear_model();
        e = 16'($urandom);
        send(e, s, lat);
        chk("clr_zero_hist", s, mdl(e));

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < ORDER; i++) wr_coef(i, 32'($urandom));
            cl = 1'($urandom);
            pulse(1'b1, cl);
            commit_model();
            if (cl) clear_model();
            for (int j = 0; j < 6; j++) begin
                e = 16'($urandom);
                send(e, s, lat);
                chk("random_sample", s, mdl(e));
                chk("random_latency", lat, ORDER + 1);
            end
        end

        accept(16'sd555);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        for (int i = 0; i < ORDER; i++) begin
            coef_m[i] = 0;
            shadow_m[i] = 0;
            hist_m[i] = 0;
        end
        send(16'sd1000, s, lat);
        m = mdl(16'sd1000);
        chk("midrst_resume", s, 1000);
        chk("midrst_latency", lat, ORDER + 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
